// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the round-robin compare scheduler: FSM encoding,
// response flag bit positions and interface widths.
package fp_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int EQ    = 0;
    localparam int LT    = 1;
    localparam int LE    = 2;
    localparam int MAGLT = 3;
    localparam int UNORD = 4;

    localparam int NREQ_DEFAULT = 4;
    localparam int ID_W         = 3;
    localparam int RSP_W        = 5;
    localparam int UO_W         = 16;

endpackage

// File: rtl/fpCompare.sv
// IEEE-754 comparator: relation flags {unord, maglt, le, lt, eq} of a against b,
// plus a flag for any signalling NaN operand.
module fpCompare
    import fp_cmp_pkg::*;
#(
    parameter int FPWID = 32
) (
    input  logic [FPWID-1:0] a,
    input  logic [FPWID-1:0] b,
    output logic [RSP_W-1:0] o,
    output logic             nanx
);

    localparam int EXP_W = (FPWID == 64) ? 11 : (FPWID == 16) ? 5 : 8;
    localparam int MAN_W = FPWID - 1 - EXP_W;

    logic             a_sign, b_sign;
    logic             a_nan, b_nan, a_snan, b_snan;
    logic             both_zero, mag_lt, lt, eq;
    logic [FPWID-2:0] a_mag, b_mag;

    always_comb begin
        a_sign    = a[FPWID-1];
        b_sign    = b[FPWID-1];
        a_mag     = a[FPWID-2:0];
        b_mag     = b[FPWID-2:0];
        a_nan     = (&a[FPWID-2 -: EXP_W]) && (|a[MAN_W-1:0]);
        b_nan     = (&b[FPWID-2 -: EXP_W]) && (|b[MAN_W-1:0]);
        a_snan    = a_nan && !a[MAN_W-1];
        b_snan    = b_nan && !b[MAN_W-1];
        both_zero = (a_mag == '0) && (b_mag == '0);
        eq        = both_zero || (a == b);
        mag_lt    = a_mag < b_mag;

        // +0 and -0 are equal, so the sign only decides once a zero pair is excluded
        if (both_zero)
            lt = 1'b0;
        else if (a_sign != b_sign)
            lt = a_sign;
        else if (a_sign)
            lt = b_mag < a_mag;
        else
            lt = mag_lt;

        o = '0;
        if (a_nan || b_nan) begin
            o[UNORD] = 1'b1;
        end else begin
            o[EQ]    = eq;
            o[LT]    = lt;
            o[LE]    = lt || eq;
            o[MAGLT] = mag_lt;
        end
        nanx = a_snan || b_snan;
    end

endmodule

// File: rtl/fp_cmp_sched.sv
// Round-robin scheduler sharing one fpCompare among NREQ requesters:
// grant in IDLE, compare in CMP, hold the response in RESP until accepted.
module fp_cmp_sched
    import fp_cmp_pkg::*;
#(
    parameter int FPWID = 32,
    parameter int NREQ  = NREQ_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*FPWID-1:0] a_i,
    input  logic [NREQ*FPWID-1:0] b_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [RSP_W-1:0]      rsp_o,
    output logic [UO_W-1:0]       uo_cnt_o,
    input  logic                  uo_clr_i
);

    localparam logic [ID_W:0]   NREQ_X  = (ID_W + 1)'(NREQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    state_e            state;
    logic              armed;
    logic [ID_W-1:0]   rr_ptr, rr_next, pick_id, pick_off, id_p0;
    logic [ID_W:0]     pick_sum;
    logic [NREQ-1:0]   req_rot;
    logic              pick_found, grant, rsp_hs;
    logic [FPWID-1:0]  a_p0, b_p0;
    logic [RSP_W-1:0]  cmp_flags;
    logic              nanx_unused;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the next owner.
    always_comb begin
        req_rot    = NREQ'({req_i, req_i} >> rr_ptr);
        pick_found = 1'b0;
        pick_off   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req_rot[off]) begin
                pick_found = 1'b1;
                pick_off   = ID_W'(off);
            end
        end
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= NREQ_X)
            pick_sum = pick_sum - NREQ_X;
        pick_id = pick_sum[ID_W-1:0];
        rr_next = (pick_id == LAST_ID) ? '0 : pick_id + 1'b1;
    end

    // armed keeps the grant quiet while reset is still being released
    assign grant  = armed && (state == ST_IDLE) && pick_found;
    assign gnt_o  = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << pick_id) : '0;
    assign rsp_hs = (state == ST_RESP) && rsp_ready_i;

    fpCompare #(
        .FPWID (FPWID)
    ) u_cmp (
        .a    (a_p0),
        .b    (b_p0),
        .o    (cmp_flags),
        .nanx (nanx_unused)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            armed       <= 1'b0;
            rr_ptr      <= '0;
            a_p0        <= '0;
            b_p0        <= '0;
            id_p0       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_o       <= '0;
            rsp_id_o    <= '0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                // p0: capture the granted requester's operands
                ST_IDLE: begin
                    if (grant) begin
                        a_p0   <= a_i[int'(pick_id) * FPWID +: FPWID];
                        b_p0   <= b_i[int'(pick_id) * FPWID +: FPWID];
                        id_p0  <= pick_id;
                        rr_ptr <= rr_next;
                        state  <= ST_CMP;
                    end
                end
                // p1: register the comparator result
                ST_CMP: begin
                    rsp_o       <= cmp_flags;
                    rsp_id_o    <= id_p0;
                    rsp_valid_o <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            uo_cnt_o <= '0;
        else if (uo_clr_i)
            uo_cnt_o <= '0;
        else if (rsp_hs && rsp_o[UNORD] && (uo_cnt_o != '1))
            uo_cnt_o <= uo_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_fp_cmp_sched.sv
// Bench for fp_cmp_sched: directed vectors plus randomized traffic checked
// against an ordering-key float model and a round-robin scoreboard.
module tb_fp_cmp_sched;

    localparam int NR = 4;
    localparam int FW = 32;

    localparam logic [31:0] DIR_A [4] = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'h7FC00000};
    localparam logic [31:0] DIR_B [4] = '{32'h40000000, 32'h80000000, 32'h3F800000, 32'h3F800000};
    localparam logic [4:0]  DIR_R [4] = '{5'b01110, 5'b00101, 5'b00110, 5'b10000};
    localparam int          RR_A  [4] = '{0, 2, 0, 2};
    localparam int          RR_B  [5] = '{0, 1, 2, 3, 0};

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [NR-1:0]    req_i;
    logic [NR*FW-1:0] a_i, b_i;
    logic [NR-1:0]    gnt_o;
    logic             rsp_valid_o, rsp_ready_i;
    logic [2:0]       rsp_id_o;
    logic [4:0]       rsp_o;
    logic [15:0]      uo_cnt_o;
    logic             uo_clr_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_rr;

    always #5 clk = ~clk;

    fp_cmp_sched #(.FPWID(FW), .NREQ(NR)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .a_i(a_i), .b_i(b_i),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_o(rsp_o), .uo_cnt_o(uo_cnt_o), .uo_clr_i(uo_clr_i)
    );

    // Floats map onto a signed ordering key: sign-magnitude becomes +/- magnitude.
    function automatic logic [4:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        logic [4:0] f;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 5'b10000;
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        f[0] = (ka == kb);
        f[1] = (ka < kb);
        f[2] = (ka <= kb);
        f[3] = (a[30:0] < b[30:0]);
        f[4] = 1'b0;
        return f;
    endfunction

    function automatic int ref_pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < NR; k++)
            if (req[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    function automatic logic [31:0] rnd_fp(input logic [31:0] other);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: rnd_fp = {r[31], 8'hFF, 1'b1, r[21:0]};
            1: rnd_fp = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            2: rnd_fp = {r[31], 31'h0};
            3: rnd_fp = other;
            4: rnd_fp = {~other[31], other[30:0]};
            5: rnd_fp = {r[31], 8'hFF, 23'h0};
            6: rnd_fp = {r[31], 8'h7F, r[22:0]};
            default: rnd_fp = r;
        endcase
    endfunction

    task automatic apply_reset();
        rst_ni = 1'b0; req_i = '0; a_i = '0; b_i = '0;
        rsp_ready_i = 1'b0; uo_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_ni = 1'b1;
        m_rr = 0;
    endtask

    // Waits for a grant, then for the response, then completes the handshake.
    task automatic serve(input int ready_wait, input bit clr_hs,
                         output logic [NR-1:0] g, output logic [4:0] r,
                         output logic [2:0] id, output int lat, output bit to);
        int n;
        to = 1'b0; g = '0; r = '0; id = '0; lat = 0; n = 0;
        #1;
        while (gnt_o === '0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (gnt_o === '0) begin
            to = 1'b1;
            return;
        end
        g = gnt_o;
        do begin
            @(negedge clk); #1; lat++;
        end while (rsp_valid_o !== 1'b1 && lat < 10);
        if (rsp_valid_o !== 1'b1) begin
            to = 1'b1;
            return;
        end
        r = rsp_o;
        id = rsp_id_o;
        repeat (ready_wait) @(negedge clk);
        #1 rsp_ready_i = 1'b1; uo_clr_i = clr_hs;
        @(negedge clk); #1;
        rsp_ready_i = 1'b0; uo_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_ni = 1'b0; req_i = 4'hF;
        @(negedge clk); #1;
        n_cmp++; if (gnt_o !== 4'h0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", gnt_o); end
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rsp_valid_o); end
        n_cmp++; if (rsp_o !== 5'b0) begin n_fail++; $display("FAIL rst_rsp: got %b want 00000", rsp_o); end
        n_cmp++; if (rsp_id_o !== 3'd0) begin n_fail++; $display("FAIL rst_id: got %0d want 0", rsp_id_o); end
        n_cmp++; if (uo_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_uo: got %0d want 0", uo_cnt_o); end
        req_i = '0;
        rst_ni = 1'b1;
    endtask

    task automatic test_directed();
        logic [NR-1:0] g; logic [4:0] r; logic [2:0] id; int lat; bit to;
        apply_reset();
        for (int k = 0; k < NR; k++) begin
            a_i = '0; b_i = '0;
            a_i[k*FW +: FW] = DIR_A[k];
            b_i[k*FW +: FW] = DIR_B[k];
            req_i = '0; req_i[k] = 1'b1;
            serve(0, 1'b0, g, r, id, lat, to);
            req_i = '0;
            n_cmp++; if (to) begin n_fail++; $display("FAIL dir_timeout k=%0d: got timeout want response", k); end
            n_cmp++; if (g !== 4'(1 << k)) begin n_fail++; $display("FAIL dir_gnt k=%0d: got %b want %b", k, g, 4'(1 << k)); end
            n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL dir_lat k=%0d: got %0d want 2", k, lat); end
            n_cmp++; if (r !== DIR_R[k]) begin n_fail++; $display("FAIL dir_rsp k=%0d: got %b want %b", k, r, DIR_R[k]); end
            n_cmp++; if (id !== 3'(k)) begin n_fail++; $display("FAIL dir_id k=%0d: got %0d want %0d", k, id, k); end
            n_cmp++; if (uo_cnt_o !== ((k == 3) ? 16'd1 : 16'd0))
                begin n_fail++; $display("FAIL dir_uo k=%0d: got %0d want %0d", k, uo_cnt_o, (k == 3) ? 1 : 0); end
        end
        req_i = 4'b1000;
        serve(1, 1'b1, g, r, id, lat, to);
        req_i = '0;
        n_cmp++; if (to) begin n_fail++; $display("FAIL clr_timeout: got timeout want response"); end
        n_cmp++; if (r !== 5'b10000) begin n_fail++; $display("FAIL clr_rsp: got %b want 10000", r); end
        n_cmp++; if (uo_cnt_o !== 16'd0) begin n_fail++; $display("FAIL clr_uo: got %0d want 0", uo_cnt_o); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g; logic [4:0] r; logic [2:0] id; int lat; bit to;
        apply_reset();
        for (int k = 0; k < NR; k++) begin
            a_i[k*FW +: FW] = 32'h3F800000;
            b_i[k*FW +: FW] = 32'h40000000;
        end
        req_i = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1'b0, g, r, id, lat, to);
            n_cmp++; if (to || id !== 3'(RR_A[i]) || g !== 4'(1 << RR_A[i]))
                begin n_fail++; $display("FAIL rr0101 step%0d: got id %0d gnt %b want id %0d", i, id, g, RR_A[i]); end
        end
        apply_reset();
        for (int k = 0; k < NR; k++) begin
            a_i[k*FW +: FW] = 32'h3F800000;
            b_i[k*FW +: FW] = 32'h40000000;
        end
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(0, 1'b0, g, r, id, lat, to);
            n_cmp++; if (to || id !== 3'(RR_B[i]) || g !== 4'(1 << RR_B[i]))
                begin n_fail++; $display("FAIL rr1111 step%0d: got id %0d gnt %b want id %0d", i, id, g, RR_B[i]); end
        end
        req_i = '0;
    endtask

    task automatic test_stall();
        logic [NR-1:0] g; logic [4:0] r; logic [2:0] id; int lat; bit to; int n;
        apply_reset();
        for (int k = 0; k < NR; k++) begin
            a_i[k*FW +: FW] = 32'h3F800000;
            b_i[k*FW +: FW] = 32'h40000000;
        end
        req_i = 4'b0001;
        #1 n = 0;
        while (gnt_o === '0 && n < 20) begin @(negedge clk); #1; n++; end
        n_cmp++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL stall_gnt: got %b want 0001", gnt_o); end
        @(negedge clk); #1 req_i = 4'b1111;
        @(negedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_o !== 5'b01110 || rsp_id_o !== 3'd0 || gnt_o !== 4'b0)
                begin n_fail++; $display("FAIL stall_hold c%0d: got v%b r%b id%0d g%b want v1 r01110 id0 g0000",
                                         c, rsp_valid_o, rsp_o, rsp_id_o, gnt_o); end
            @(negedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk); #1 rsp_ready_i = 1'b0;
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_drop: got %b want 0", rsp_valid_o); end
        n_cmp++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL stall_idle_gnt: got %b want 0010", gnt_o); end
        serve(0, 1'b0, g, r, id, lat, to);
        req_i = '0;
        n_cmp++; if (to || id !== 3'd1) begin n_fail++; $display("FAIL stall_next_id: got %0d want 1", id); end
    endtask

    task automatic test_reset_abort();
        logic [NR-1:0] g; logic [4:0] r; logic [2:0] id; int lat; bit to; int n;
        apply_reset();
        a_i[3*FW +: FW] = 32'h7FC00000;
        b_i[3*FW +: FW] = 32'h3F800000;
        req_i = 4'b1000;
        #1 n = 0;
        while (gnt_o === '0 && n < 20) begin @(negedge clk); #1; n++; end
        n_cmp++; if (gnt_o !== 4'b1000) begin n_fail++; $display("FAIL abort_gnt: got %b want 1000", gnt_o); end
        @(negedge clk); #1;
        rst_ni = 1'b0;
        req_i = 4'b0001;
        a_i[0 +: FW] = 32'h3F800000;
        b_i[0 +: FW] = 32'h3F800000;
        @(negedge clk); #1;
        n_cmp++; if ({gnt_o, rsp_valid_o, rsp_o, rsp_id_o} !== '0)
            begin n_fail++; $display("FAIL abort_outs: got g%b v%b r%b id%0d want all 0", gnt_o, rsp_valid_o, rsp_o, rsp_id_o); end
        n_cmp++; if (uo_cnt_o !== 16'd0) begin n_fail++; $display("FAIL abort_uo: got %0d want 0", uo_cnt_o); end
        rst_ni = 1'b1;
        serve(0, 1'b0, g, r, id, lat, to);
        req_i = '0;
        n_cmp++; if (to || g !== 4'b0001 || id !== 3'd0) begin n_fail++; $display("FAIL abort_fresh: got g%b id%0d want g0001 id0", g, id); end
        n_cmp++; if (r !== 5'b00101 || lat !== 2) begin n_fail++; $display("FAIL abort_rsp: got %b lat %0d want 00101 lat 2", r, lat); end
        n_cmp++; if (uo_cnt_o !== 16'd0) begin n_fail++; $display("FAIL abort_uo_after: got %0d want 0", uo_cnt_o); end
    endtask

    task automatic test_random();
        logic [NR-1:0] g; logic [4:0] r; logic [2:0] id; int lat; bit to;
        logic [31:0] ma [NR];
        logic [31:0] mb [NR];
        logic [3:0] mask; logic [4:0] er; int eid; int m_uo; bit clr;
        apply_reset();
        m_uo = 0;
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < NR; k++) begin
                ma[k] = rnd_fp($urandom);
                mb[k] = rnd_fp(ma[k]);
                a_i[k*FW +: FW] = ma[k];
                b_i[k*FW +: FW] = mb[k];
            end
            mask = 4'($urandom_range(1, 15));
            clr = ($urandom_range(0, 9) == 0);
            req_i = mask;
            serve($urandom_range(0, 2), clr, g, r, id, lat, to);
            req_i = '0;
            eid = ref_pick(mask, m_rr);
            er = ref_cmp(ma[eid], mb[eid]);
            m_rr = (eid + 1) % NR;
            if (clr) m_uo = 0;
            else if (er[4] && m_uo < 65535) m_uo++;
            n_cmp++; if (to) begin n_fail++; $display("FAIL rnd_timeout t%0d: got timeout want response", t); end
            n_cmp++; if (g !== 4'(1 << eid) || id !== 3'(eid))
                begin n_fail++; $display("FAIL rnd_arb t%0d mask %b: got g%b id%0d want id%0d", t, mask, g, id, eid); end
            n_cmp++; if (r !== er)
                begin n_fail++; $display("FAIL rnd_rsp t%0d a=%h b=%h: got %b want %b", t, ma[eid], mb[eid], r, er); end
            n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL rnd_lat t%0d: got %0d want 2", t, lat); end
            n_cmp++; if (uo_cnt_o !== 16'(m_uo)) begin n_fail++; $display("FAIL rnd_uo t%0d: got %0d want %0d", t, uo_cnt_o, m_uo); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_stall();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
